adsr_env_detector: RTL and testbench

//  Envelope follower: inverse of the ADSR generator. Takes a stream of signed Q2.14 audio samples,

---
 rtl/adsr_env_detector.sv | 139 +++++++++++++
 tb/tb_adsr_env_detector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adsr_env_detector.sv
// Envelope follower: rectifies Q2.14 samples, slews a Q1.31 envelope,
// and drives a hysteretic note gate with a hold timer.
module adsr_env_detector #(
    parameter int HOLD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [15:0]       sample_in,
    input  logic [31:0]       atk_step,
    input  logic [31:0]       rel_step,
    input  logic [31:0]       on_thresh,
    input  logic [31:0]       off_thresh,
    input  logic [HOLD_W-1:0] hold_time,
    input  logic              clear,
    output logic [15:0]       env,
    output logic              env_valid,
    output logic              gate,
    output logic              gate_rise,
    output logic              gate_fall,
    output logic              det_idle
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_HOLD
    } state_t;

    localparam logic [31:0] BYPASS = 32'hFFFF_FFFF;

    logic [31:0]       e_q, e_d;
    logic              ev_q, ev_d;
    state_t            st_q, st_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    logic [15:0] mag;
    logic [14:0] mag_c;
    logic [31:0] m32;
    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        mag   = sample_in[15] ? (~sample_in + 16'd1) : sample_in;
        // -2.0 rectifies to 16'h8000, which the clamp also catches
        mag_c = (mag > 16'h4000) ? 15'h4000 : mag[14:0];
        m32   = {mag_c, 17'b0};
        sum   = {1'b0, e_q} + {1'b0, atk_step};
        diff  = {1'b0, e_q} - {1'b0, rel_step};

        e_d = e_q;
        if (sample_valid) begin
            if (m32 > e_q) begin
                if (atk_step == BYPASS || sum > {1'b0, m32}) begin
                    e_d = m32;
                end else begin
                    e_d = sum[31:0];
                end
            end else if (m32 < e_q) begin
                if (diff[32] || diff[31:0] < m32) begin
                    e_d = m32;
                end else begin
                    e_d = diff[31:0];
                end
            end
        end
        ev_d = sample_valid;

        st_d   = st_q;
        cnt_d  = cnt_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (ev_q) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (e_q >= on_thresh) begin
                        st_d   = ST_ON;
                        rise_d = 1'b1;
                    end
                end
                ST_ON: begin
                    if (e_q < off_thresh) begin
                        st_d  = ST_HOLD;
                        cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (e_q >= on_thresh) begin
                        st_d = ST_ON;
                    end else if (cnt_q < hold_time) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        st_d   = ST_IDLE;
                        fall_d = 1'b1;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        // clear wins over a coincident sample or FSM step
        if (clear) begin
            e_d    = '0;
            ev_d   = 1'b0;
            st_d   = ST_IDLE;
            cnt_d  = '0;
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q    <= '0;
            ev_q   <= 1'b0;
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            e_q    <= e_d;
            ev_q   <= ev_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign env       = {1'b0, e_q[31:17]};
    assign env_valid = ev_q;
    assign gate      = (st_q != ST_IDLE);
    assign det_idle  = (st_q == ST_IDLE);
    assign gate_rise = rise_q;
    assign gate_fall = fall_q;

endmodule

// File: tb/tb_adsr_env_detector.sv
// Randomized and directed bench for adsr_env_detector against
// an arithmetic reference model of the envelope and gate.
module tb_adsr_env_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        sv;
    logic [15:0] sin;
    logic [31:0] atk, rel, on_t, off_t;
    logic [31:0] hold;
    logic        clr;
    logic [15:0] env;
    logic        env_valid, gate, gate_rise, gate_fall, det_idle;

    always #5 clk = ~clk;

    adsr_env_detector #(.HOLD_W(32)) dut (
        .clk(clk), .reset(reset), .sample_valid(sv), .sample_in(sin),
        .atk_step(atk), .rel_step(rel), .on_thresh(on_t),
        .off_thresh(off_t), .hold_time(hold), .clear(clr),
        .env(env), .env_valid(env_valid), .gate(gate),
        .gate_rise(gate_rise), .gate_fall(gate_fall), .det_idle(det_idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // model: 0 idle, 1 on, 2 hold
    longint m_e;
    bit     m_ev;
    int     m_st;
    longint m_cnt;
    bit     m_rise, m_fall;

    function automatic longint level_of(logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 16384) v = 16384;
        return longint'(v) * 131072;
    endfunction

    task automatic model_step();
        longint m, t;
        if (reset || clr) begin
            m_e = 0; m_ev = 0; m_st = 0; m_cnt = 0;
            m_rise = 0; m_fall = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_ev) begin
                if (m_st == 0) begin
                    if (m_e >= longint'(on_t)) begin
                        m_st = 1; m_rise = 1;
                    end
                end else if (m_st == 1) begin
                    if (m_e < longint'(off_t)) begin
                        m_st = 2; m_cnt = 0;
                    end
                end else begin
                    if (m_e >= longint'(on_t)) m_st = 1;
                    else if (m_cnt < longint'(hold)) m_cnt++;
                    else begin
                        m_st = 0; m_fall = 1;
                    end
                end
            end
            if (sv) begin
                m = level_of(sin);
                if (m > m_e) begin
                    if (atk == 32'hFFFF_FFFF) m_e = m;
                    else begin
                        t = m_e + longint'(atk);
                        m_e = (t < m) ? t : m;
                    end
                end else if (m < m_e) begin
                    t = m_e - longint'(rel);
                    m_e = (t > m) ? t : m;
                end
            end
            m_ev = sv;
        end
    endtask

    task automatic cyc();
        logic [31:0] exp_env;
        model_step();
        @(posedge clk);
        #1;
        exp_env = 32'(m_e / 131072);
        chk("env", {16'b0, env}, exp_env);
        chk("env_valid", {31'b0, env_valid}, {31'b0, m_ev});
        chk("gate", {31'b0, gate}, {31'b0, m_st != 0});
        chk("det_idle", {31'b0, det_idle}, {31'b0, m_st == 0});
        chk("gate_rise", {31'b0, gate_rise}, {31'b0, m_rise});
        chk("gate_fall", {31'b0, gate_fall}, {31'b0, m_fall});
        sv  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic smp(logic [15:0] s);
        sin = s;
        sv  = 1'b1;
        cyc();
    endtask

    int falls;

    initial begin
        reset = 1'b1; sv = 1'b0; sin = '0; clr = 1'b0;
        atk = 32'hFFFF_FFFF; rel = 32'hFFFF_FFFF;
        on_t = 32'hFFFF_FFFF; off_t = 32'h0; hold = 0;
        #2;
        cyc();
        cyc();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) cyc();
        chk("rst_idle", {31'b0, det_idle}, 32'd1);
        chk("rst_env", {16'b0, env}, 32'd0);

        smp(16'h2000);
        chk("inst_atk", {16'b0, env}, 32'h2000);
        smp(16'hC000);
        chk("inst_neg", {16'b0, env}, 32'h4000);

        smp(16'h0000);
        atk = 32'h1000_0000;
        rel = 32'h0800_0000;
        for (int i = 0; i < 8; i++) smp(16'h4000);
        chk("slew_top", {16'b0, env}, 32'h4000);
        for (int i = 0; i < 15; i++) smp(16'h0000);
        chk("slew_15", {16'b0, env}, 32'h0400);
        smp(16'h0000);
        chk("slew_bot", {16'b0, env}, 32'h0);

        atk = 32'hFFFF_FFFF; rel = 32'hFFFF_FFFF;
        on_t = 32'h4000_0000; off_t = 32'h2000_0000; hold = 3;
        clr = 1'b1;
        cyc();
        smp(16'h3000);
        cyc();
        chk("g_rise", {31'b0, gate_rise}, 32'd1);
        falls = 0;
        for (int i = 0; i < 5; i++) begin
            smp(16'h0000);
            if (gate_fall) falls++;
        end
        cyc();
        if (gate_fall) falls++;
        chk("g_fall_once", falls, 32'd1);
        chk("g_fall_idle", {31'b0, det_idle}, 32'd1);
        smp(16'h3000);
        smp(16'h0000);
        smp(16'h0000);
        smp(16'h3000);
        cyc();
        chk("rehit_gate", {31'b0, gate}, 32'd1);
        chk("rehit_norise", {31'b0, gate_rise}, 32'd0);

        smp(16'h8000);
        chk("clamp_neg2", {16'b0, env}, 32'h4000);
        smp(16'h0000);
        smp(16'h7FFF);
        chk("clamp_pos", {16'b0, env}, 32'h4000);
        cyc();

        chk("pre_clr_gate", {31'b0, gate}, 32'd1);
        clr = 1'b1;
        sin = 16'h1000;
        sv  = 1'b1;
        cyc();
        chk("clr_env", {16'b0, env}, 32'd0);
        chk("clr_gate", {31'b0, gate}, 32'd0);
        chk("clr_idle", {31'b0, det_idle}, 32'd1);
        cyc();
        chk("clr_nofall", {31'b0, gate_fall}, 32'd0);

        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(0, 3))
                0: atk = 32'hFFFF_FFFF;
                1: atk = $urandom_range(32'h0100_0000, 32'h4000_0000);
                default: atk = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rel = 32'h0;
                1: rel = 32'hFFFF_FFFF;
                2: rel = $urandom_range(32'h0010_0000, 32'h2000_0000);
                default: rel = $urandom;
            endcase
            on_t  = $urandom_range(32'h0800_0000, 32'h8800_0000);
            off_t = $urandom_range(32'h0, 32'h7000_0000);
            if (blk % 7 != 3 && off_t > on_t) off_t = on_t;
            hold = $urandom_range(0, 5);
            for (int i = 0; i < 150; i++) begin
                sv  = ($urandom_range(0, 9) < 7);
                clr = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 3) == 0) sin = 16'h0;
                else sin = 16'($urandom);
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
